// File: rtl/tm1638_slave_rx_if.sv
// TM1638 receive-side bundle: serial master lines in, RAM write port and control state out.
// Latency: none (wires only).
// Backpressure: none; the serial master cannot be stalled.
interface tm1638_slave_rx_if;
    // Serial lines driven by the TM1638 master
    logic       stb_i;
    logic       sclk_i;
    logic       dio_i;
    // Decoded results
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       disp_on;
    logic [2:0] brightness;
    logic       fixed_addr;
    logic       frame_done;
    logic       frame_err;

    modport slave (
        input  stb_i, sclk_i, dio_i,
        output ram_we, ram_addr, ram_wdata, disp_on, brightness,
               fixed_addr, frame_done, frame_err
    );

    modport master (
        output stb_i, sclk_i, dio_i,
        input  ram_we, ram_addr, ram_wdata, disp_on, brightness,
               fixed_addr, frame_done, frame_err
    );
endinterface

// File: rtl/tm1638_slave_rx.sv
// TM1638 serial receiver: oversamples STB/CLK/DIO, decodes LSB-first commands into RAM writes and control state.
// Latency: write/register update 1 clk after the 8th synced sclk rising edge (SYNC_STAGES+1 clk after the pin edge).
// Backpressure: none; ram_we is a one-cycle strobe the consumer must accept.
module tm1638_slave_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    tm1638_slave_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_CMD,
        S_DATA,
        S_IGNORE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_stb_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_dio_sync;
    logic                   r_stb_d;
    logic                   r_sclk_d;
    // Only the seven most recent bits are kept; the 8th arrives live from w_dio.
    logic [6:0]             r_shreg;
    logic [2:0]             r_bitcnt;
    logic                   r_got_byte;
    logic [3:0]             r_addr;
    logic                   r_ram_we;
    logic [3:0]             r_ram_addr;
    logic [7:0]             r_ram_wdata;
    logic                   r_disp_on;
    logic [2:0]             r_brightness;
    logic                   r_fixed_addr;
    logic                   r_frame_done;
    logic                   r_frame_err;

    logic       w_stb;
    logic       w_sclk;
    logic       w_dio;
    logic       w_stb_rise;
    logic       w_stb_fall;
    logic       w_sclk_rise;
    logic       w_bit_take;
    logic       w_byte_done;
    logic [7:0] w_byte;
    logic [2:0] w_cnt_after;
    logic       w_got_after;

    // Synchronize the asynchronous serial lines and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stb_sync  <= '0;
            r_sclk_sync <= '0;
            r_dio_sync  <= '0;
            r_stb_d     <= 1'b0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_stb_sync  <= {r_stb_sync[SYNC_STAGES-2:0], bus.stb_i};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk_i};
            r_dio_sync  <= {r_dio_sync[SYNC_STAGES-2:0], bus.dio_i};
            r_stb_d     <= w_stb;
            r_sclk_d    <= w_sclk;
        end
    end

    assign w_stb       = r_stb_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_dio       = r_dio_sync[SYNC_STAGES-1];
    assign w_stb_rise  = w_stb & ~r_stb_d;
    assign w_stb_fall  = ~w_stb & r_stb_d;
    assign w_sclk_rise = w_sclk & ~r_sclk_d;

    // Bits are only collected inside an open frame; IGNORE/IDLE drop sclk edges.
    assign w_bit_take  = ((r_state == S_CMD) || (r_state == S_DATA)) && w_sclk_rise;
    assign w_byte      = {w_dio, r_shreg};
    assign w_byte_done = w_bit_take && (r_bitcnt == 3'd7);
    // Counter and byte flag as they stand after this cycle's bit, so a byte finishing
    // in the same cycle as the stb rise closes the frame cleanly.
    assign w_cnt_after = w_bit_take ? (r_bitcnt + 3'd1) : r_bitcnt;
    assign w_got_after = r_got_byte | w_byte_done;

    // Frame FSM: bit collection, command decode, RAM writes and frame status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_WAIT_IDLE;
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_got_byte   <= 1'b0;
            r_addr       <= '0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_disp_on    <= 1'b0;
            r_brightness <= '0;
            r_fixed_addr <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_ram_we     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state == S_WAIT_IDLE) begin
                // A frame cut by reset is skipped until the strobe goes idle.
                if (w_stb) begin
                    r_state <= S_IDLE;
                end
            end else begin
                if (w_bit_take) begin
                    r_shreg  <= w_byte[7:1];
                    r_bitcnt <= w_cnt_after;
                end
                if (w_byte_done) begin
                    r_got_byte <= 1'b1;
                    if (r_state == S_CMD) begin
                        case (w_byte[7:6])
                            2'b01: begin
                                if (w_byte[1:0] == 2'b00) begin
                                    r_fixed_addr <= w_byte[2];
                                end else begin
                                    // Key-scan read and test modes are not emulated.
                                    r_frame_err <= 1'b1;
                                end
                                r_state <= S_IGNORE;
                            end
                            2'b11: begin
                                r_addr  <= w_byte[3:0];
                                r_state <= S_DATA;
                            end
                            2'b10: begin
                                r_disp_on    <= w_byte[3];
                                r_brightness <= w_byte[2:0];
                                r_state      <= S_IGNORE;
                            end
                            default: begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_IGNORE;
                            end
                        endcase
                    end else begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_addr;
                        r_ram_wdata <= w_byte;
                        if (!r_fixed_addr) begin
                            r_addr <= r_addr + 4'd1;
                        end
                    end
                end
                // Strobe edges override the next state chosen above.
                if (w_stb_fall) begin
                    r_state    <= S_CMD;
                    r_bitcnt   <= '0;
                    r_got_byte <= 1'b0;
                end else if (w_stb_rise) begin
                    if (w_cnt_after != 3'd0) begin
                        r_frame_err <= 1'b1;
                    end else if (w_got_after) begin
                        r_frame_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign bus.ram_we     = r_ram_we;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_wdata  = r_ram_wdata;
    assign bus.disp_on    = r_disp_on;
    assign bus.brightness = r_brightness;
    assign bus.fixed_addr = r_fixed_addr;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_tm1638_slave_rx.sv
// Directed bench for tm1638_slave_rx: drives serial frames and checks writes, control state and frame pulses.
// Latency: n/a.
// Backpressure: n/a.
module tb_tm1638_slave_rx;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tm1638_slave_rx_if bus();

    tm1638_slave_rx #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock offset by 2 ns so stimulus at multiples of 10 ns never lands on an edge.
    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    // Observed writes and pulse cycles, sampled on the falling edge.
    logic [3:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         done_cnt = 0;
    int         err_cnt  = 0;

    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            wr_addr.push_back(bus.ram_addr);
            wr_data.push_back(bus.ram_wdata);
        end
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    int b_wr;
    int b_done;
    int b_err;

    task automatic mark();
        b_wr   = wr_addr.size();
        b_done = done_cnt;
        b_err  = err_cnt;
    endtask

    // sclk half period 200 ns = 20 clk, well above the minimum.
    task automatic send_bits(input logic [7:0] b, input int n, input bit close);
        for (int i = 0; i < n; i++) begin
            bus.sclk_i = 1'b0;
            bus.dio_i  = b[i];
            #200;
            bus.sclk_i = 1'b1;
            if (close && (i == n - 1)) bus.stb_i = 1'b1;
            #200;
        end
    endtask

    task automatic start_frame();
        bus.stb_i = 1'b0;
        #400;
    endtask

    task automatic end_frame();
        #200;
        bus.stb_i = 1'b1;
        #800;
    endtask

    task automatic frame1(input logic [7:0] b0);
        start_frame();
        send_bits(b0, 8, 1'b0);
        end_frame();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.stb_i  = 1'b1;
        bus.sclk_i = 1'b1;
        bus.dio_i  = 1'b0;
        #50;
        total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b exp=0", bus.ram_we); end
        total++; if (bus.ram_addr !== 4'h0) begin bad++; $display("FAIL reset_ram_addr got=%h exp=0", bus.ram_addr); end
        total++; if (bus.ram_wdata !== 8'h00) begin bad++; $display("FAIL reset_ram_wdata got=%h exp=00", bus.ram_wdata); end
        total++; if (bus.disp_on !== 1'b0) begin bad++; $display("FAIL reset_disp_on got=%b exp=0", bus.disp_on); end
        total++; if (bus.brightness !== 3'd0) begin bad++; $display("FAIL reset_brightness got=%0d exp=0", bus.brightness); end
        total++; if (bus.fixed_addr !== 1'b0) begin bad++; $display("FAIL reset_fixed_addr got=%b exp=0", bus.fixed_addr); end
        total++; if ({bus.frame_done, bus.frame_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {bus.frame_done, bus.frame_err}); end
        rst = 1'b0;
        #200;
    endtask

    task automatic test_auto_inc();
        mark();
        frame1(8'h40);
        start_frame();
        send_bits(8'hC0, 8, 1'b0);
        send_bits(8'h3F, 8, 1'b0);
        send_bits(8'h06, 8, 1'b0);
        send_bits(8'h5B, 8, 1'b0);
        end_frame();
        total++; if (wr_addr.size() - b_wr !== 3) begin bad++; $display("FAIL auto_count got=%0d exp=3", wr_addr.size() - b_wr); end
        total++; if ({wr_addr[b_wr], wr_data[b_wr]} !== {4'd0, 8'h3F}) begin bad++; $display("FAIL auto_w0 got=%h/%h exp=0/3f", wr_addr[b_wr], wr_data[b_wr]); end
        total++; if ({wr_addr[b_wr+1], wr_data[b_wr+1]} !== {4'd1, 8'h06}) begin bad++; $display("FAIL auto_w1 got=%h/%h exp=1/06", wr_addr[b_wr+1], wr_data[b_wr+1]); end
        total++; if ({wr_addr[b_wr+2], wr_data[b_wr+2]} !== {4'd2, 8'h5B}) begin bad++; $display("FAIL auto_w2 got=%h/%h exp=2/5b", wr_addr[b_wr+2], wr_data[b_wr+2]); end
        total++; if (done_cnt - b_done !== 2) begin bad++; $display("FAIL auto_done got=%0d exp=2", done_cnt - b_done); end
        total++; if (err_cnt - b_err !== 0) begin bad++; $display("FAIL auto_err got=%0d exp=0", err_cnt - b_err); end
    endtask

    task automatic test_fixed();
        mark();
        frame1(8'h44);
        total++; if (bus.fixed_addr !== 1'b1) begin bad++; $display("FAIL fixed_flag got=%b exp=1", bus.fixed_addr); end
        start_frame();
        send_bits(8'hC5, 8, 1'b0);
        send_bits(8'hAA, 8, 1'b0);
        end_frame();
        start_frame();
        send_bits(8'hC5, 8, 1'b0);
        send_bits(8'h55, 8, 1'b0);
        end_frame();
        total++; if (wr_addr.size() - b_wr !== 2) begin bad++; $display("FAIL fixed_count got=%0d exp=2", wr_addr.size() - b_wr); end
        total++; if ({wr_addr[b_wr], wr_data[b_wr]} !== {4'd5, 8'hAA}) begin bad++; $display("FAIL fixed_w0 got=%h/%h exp=5/aa", wr_addr[b_wr], wr_data[b_wr]); end
        total++; if ({wr_addr[b_wr+1], wr_data[b_wr+1]} !== {4'd5, 8'h55}) begin bad++; $display("FAIL fixed_w1 got=%h/%h exp=5/55", wr_addr[b_wr+1], wr_data[b_wr+1]); end
        total++; if (done_cnt - b_done !== 3) begin bad++; $display("FAIL fixed_done got=%0d exp=3", done_cnt - b_done); end
    endtask

    task automatic test_wrap();
        mark();
        frame1(8'h40);
        total++; if (bus.fixed_addr !== 1'b0) begin bad++; $display("FAIL wrap_flag got=%b exp=0", bus.fixed_addr); end
        start_frame();
        send_bits(8'hCF, 8, 1'b0);
        send_bits(8'h11, 8, 1'b0);
        send_bits(8'h22, 8, 1'b0);
        end_frame();
        total++; if (wr_addr.size() - b_wr !== 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", wr_addr.size() - b_wr); end
        total++; if ({wr_addr[b_wr], wr_data[b_wr]} !== {4'd15, 8'h11}) begin bad++; $display("FAIL wrap_w0 got=%h/%h exp=f/11", wr_addr[b_wr], wr_data[b_wr]); end
        total++; if ({wr_addr[b_wr+1], wr_data[b_wr+1]} !== {4'd0, 8'h22}) begin bad++; $display("FAIL wrap_w1 got=%h/%h exp=0/22", wr_addr[b_wr+1], wr_data[b_wr+1]); end
    endtask

    task automatic test_ctrl();
        mark();
        frame1(8'h8C);
        total++; if (bus.disp_on !== 1'b1) begin bad++; $display("FAIL ctrl_on got=%b exp=1", bus.disp_on); end
        total++; if (bus.brightness !== 3'b100) begin bad++; $display("FAIL ctrl_bright got=%b exp=100", bus.brightness); end
        total++; if (wr_addr.size() - b_wr !== 0) begin bad++; $display("FAIL ctrl_nowrite got=%0d exp=0", wr_addr.size() - b_wr); end
        total++; if (done_cnt - b_done !== 1) begin bad++; $display("FAIL ctrl_done got=%0d exp=1", done_cnt - b_done); end
        frame1(8'h80);
        total++; if ({bus.disp_on, bus.brightness} !== 4'b0000) begin bad++; $display("FAIL ctrl_off got=%b exp=0000", {bus.disp_on, bus.brightness}); end
    endtask

    task automatic test_partial();
        mark();
        start_frame();
        send_bits(8'hC3, 8, 1'b0);
        send_bits(8'hFF, 5, 1'b0);
        end_frame();
        total++; if (wr_addr.size() - b_wr !== 0) begin bad++; $display("FAIL partial_nowrite got=%0d exp=0", wr_addr.size() - b_wr); end
        total++; if (err_cnt - b_err !== 1) begin bad++; $display("FAIL partial_err got=%0d exp=1", err_cnt - b_err); end
        total++; if (done_cnt - b_done !== 0) begin bad++; $display("FAIL partial_done got=%0d exp=0", done_cnt - b_done); end
        mark();
        start_frame();
        send_bits(8'hC3, 8, 1'b0);
        send_bits(8'h7F, 8, 1'b0);
        end_frame();
        total++; if (wr_addr.size() - b_wr !== 1) begin bad++; $display("FAIL partial_next_count got=%0d exp=1", wr_addr.size() - b_wr); end
        total++; if ({wr_addr[b_wr], wr_data[b_wr]} !== {4'd3, 8'h7F}) begin bad++; $display("FAIL partial_next_w got=%h/%h exp=3/7f", wr_addr[b_wr], wr_data[b_wr]); end
        total++; if ({done_cnt - b_done, err_cnt - b_err} !== {32'd1, 32'd0}) begin bad++; $display("FAIL partial_next_pulses got=%0d/%0d exp=1/0", done_cnt - b_done, err_cnt - b_err); end
    endtask

    // Last sclk rise and stb rise on the same instant reach the core in the same cycle.
    task automatic test_same_edge();
        mark();
        start_frame();
        send_bits(8'hC2, 8, 1'b0);
        send_bits(8'hA5, 8, 1'b1);
        #800;
        total++; if (wr_addr.size() - b_wr !== 1) begin bad++; $display("FAIL same_count got=%0d exp=1", wr_addr.size() - b_wr); end
        total++; if ({wr_addr[b_wr], wr_data[b_wr]} !== {4'd2, 8'hA5}) begin bad++; $display("FAIL same_w got=%h/%h exp=2/a5", wr_addr[b_wr], wr_data[b_wr]); end
        total++; if (err_cnt - b_err !== 0) begin bad++; $display("FAIL same_err got=%0d exp=0", err_cnt - b_err); end
        total++; if (done_cnt - b_done !== 1) begin bad++; $display("FAIL same_done got=%0d exp=1", done_cnt - b_done); end
    endtask

    task automatic test_key_read_reset();
        frame1(8'h44);
        frame1(8'h8F);
        total++; if (bus.disp_on !== 1'b1) begin bad++; $display("FAIL key_pre_on got=%b exp=1", bus.disp_on); end
        mark();
        start_frame();
        send_bits(8'h42, 8, 1'b0);
        send_bits(8'hC1, 8, 1'b0);
        send_bits(8'h11, 8, 1'b0);
        end_frame();
        total++; if (err_cnt - b_err !== 1) begin bad++; $display("FAIL key_err got=%0d exp=1", err_cnt - b_err); end
        total++; if (wr_addr.size() - b_wr !== 0) begin bad++; $display("FAIL key_nowrite got=%0d exp=0", wr_addr.size() - b_wr); end
        // Reset in the middle of a data byte.
        mark();
        start_frame();
        send_bits(8'hC0, 8, 1'b0);
        send_bits(8'h99, 4, 1'b0);
        rst = 1'b1;
        #20;
        total++; if ({bus.disp_on, bus.brightness, bus.fixed_addr} !== 5'b00000) begin bad++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {bus.disp_on, bus.brightness, bus.fixed_addr}); end
        total++; if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== 13'd0) begin bad++; $display("FAIL rst_mid_ram got=%h exp=0", {bus.ram_we, bus.ram_addr, bus.ram_wdata}); end
        rst = 1'b0;
        send_bits(8'h09, 4, 1'b0);
        send_bits(8'h66, 8, 1'b0);
        end_frame();
        total++; if (wr_addr.size() - b_wr !== 0) begin bad++; $display("FAIL rst_mid_nowrite got=%0d exp=0", wr_addr.size() - b_wr); end
        mark();
        start_frame();
        send_bits(8'hC0, 8, 1'b0);
        send_bits(8'h77, 8, 1'b0);
        end_frame();
        total++; if (wr_addr.size() - b_wr !== 1) begin bad++; $display("FAIL rst_after_count got=%0d exp=1", wr_addr.size() - b_wr); end
        total++; if ({wr_addr[b_wr], wr_data[b_wr]} !== {4'd0, 8'h77}) begin bad++; $display("FAIL rst_after_w got=%h/%h exp=0/77", wr_addr[b_wr], wr_data[b_wr]); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_auto_inc();
        test_fixed();
        test_wrap();
        test_ctrl();
        test_partial();
        test_same_edge();
        test_key_read_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
